io_serdes_gen: RTL
==================

Name: io_serdes_gen

Overview:
Parametrised successor of the byte-wide operand/result serialiser. It deserialises N_OPS operands of WORD_W bits from a BUS_W-bit input bus under a valid strobe, then pulses start_calc to the arithmetic core. It captures the result on calc_done and streams it back over the BUS_W bus under a ready/valid handshake. Byte order (MSB-first or LSB-first) is selectable per transaction.

Parameters:
BUS_W, 8, width of the external input and output buses
WORD_W, 32, width of each operand and of the result; WORD_W % BUS_W == 0 and BEATS = WORD_W/BUS_W >= 2
N_OPS, 2, number of operands per transaction; N_OPS >= 1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  inputs carries a valid beat this cycle
inputs  input  BUS_W  inbound beat
msb_first  input  1  1 = most-significant beat first, 0 = least-significant beat first
operands  output  N_OPS*WORD_W  operand i at [WORD_W*i +: WORD_W]
start_calc  output  1  one-cycle pulse when all operands are loaded
calc_done  input  1  result z is valid
z  input  WORD_W  result from the core
outputs  output  BUS_W  outbound beat (registered)
out_valid  output  1  outputs holds a valid beat
out_ready  input  1  sink accepts the beat this cycle
overrun  output  1  one-cycle pulse when in_valid arrives outside LOAD

Behaviour:
- Reset (reset=0, asynchronous): state LOAD; beat_cnt, op_cnt and mode_q cleared; operands=0, outputs=0, out_valid=0, start_calc=0, overrun=0. Reset is honoured mid-transaction, and the partial transaction is discarded.
- FSM states: LOAD -> CALC -> OUT -> LOAD.
- Mode latching: mode_q <= msb_first on the first accepted beat of a transaction (LOAD, op_cnt=0, beat_cnt=0). mode_q is used for the entire transaction, including the output phase.
- LOAD:
  - Every cycle with in_valid=1 consumes one beat. Cycles with in_valid=0 are gaps and change nothing.
  - mode_q=1: operand[op_cnt] <= {operand[op_cnt][WORD_W-BUS_W-1:0], inputs}.
  - mode_q=0: inputs is written to slice [BUS_W*beat_cnt +: BUS_W].
  - beat_cnt wraps at BEATS-1, then op_cnt increments.
  - On the last beat of operand N_OPS-1: go to CALC, and start_calc=1 for exactly the next cycle.
- operands update only in LOAD. They are held stable through CALC and OUT until the next transaction's first beat.
- CALC:
  - calc_done is sampled every cycle, including the start_calc cycle.
  - On calc_done=1: z is captured into the result register, outputs is preloaded with the first beat (MSB if mode_q=1, LSB otherwise), out_valid <= 1, state -> OUT.
- OUT:
  - A beat transfers when out_valid & out_ready. The next beat then appears on the following cycle.
  - With out_ready=0, outputs and out_valid hold.
  - After the final beat transfers: out_valid <= 0, outputs <= 0, counters cleared, state -> LOAD. A new beat can be accepted on the next cycle.
- in_valid=1 in CALC or OUT: the beat is dropped and overrun pulses for one cycle. calc_done outside CALC is ignored.
- Latency:
  - Last input beat to start_calc: 1 cycle.
  - calc_done to first out_valid: 1 cycle.
  - With out_ready held high: one beat per cycle.

Optional Feature:
IO_SERDES_CHECKSUM_EN:
- Defined: one extra output beat follows the result beats. Its value is the XOR of all BEATS result beats, and it uses the same handshake. LOAD is re-entered only after the checksum beat transfers.
- Undefined: exactly BEATS output beats and no checksum logic.

Decomposition:
- Package io_serdes_pkg holds:
  - state enum typedef (LOAD, CALC, OUT);
  - default BUS_W/WORD_W/N_OPS constants;
  - beats-count localparam function;
  - counter-width helper ($clog2-based).
- One sub-module, io_serdes_word: a single WORD_W register with beat-write (both orders) and beat-select read. It is instantiated N_OPS times for the operands and once for the result.

Test Plan:
- Defaults, msb_first=1, in_valid=1, inputs DE AD BE EF AB CD EF 12 -> operands[31:0]=DEADBEEF, operands[63:32]=ABCDEF12; start_calc high for exactly 1 cycle, the cycle after beat 12.
- Continue with calc_done=1, z=ABFF7892, out_ready=1 -> outputs AB, FF, 78, 92 on 4 consecutive valid cycles; then out_valid=0, outputs=00, state LOAD.
- msb_first=0, inputs EF BE AD DE 12 EF CD AB, z=ABFF7892 -> operand0=DEADBEEF, operand1=ABCDEF12; outputs 92, 78, FF, AB.
- out_ready pattern 1,0,0,1,1,0,1 during OUT -> each beat holds while out_ready=0; no beat lost or duplicated.
- in_valid gaps during LOAD, plus in_valid=1 during CALC with inputs=55 -> gaps ignored; overrun pulses once; operands unchanged.
- reset asserted mid-OUT after beat FF -> out_valid=0 immediately; after release, a fresh load DE AD BE EF ... loads correctly. With IO_SERDES_CHECKSUM_EN, z=ABFF7892 -> 5th beat BE.

Source files
------------

// File: rtl/io_serdes_pkg.sv
// io_serdes_pkg: shared types, default sizing and helpers for the io_serdes_gen
// operand/result serialiser slice.
//   state_e   : controller phase (LOAD, CALC, OUT)
//   DEF_*     : default bus width, word width and operand count
//   beats_of  : number of bus beats per word
//   cnt_w     : counter width able to hold values 0..n-1
package io_serdes_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int unsigned DEF_BUS_W  = 8;
  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_N_OPS  = 2;

  function automatic int unsigned beats_of(input int unsigned word_w, input int unsigned bus_w);
    return word_w / bus_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_serdes_word.sv
// io_serdes_word: one WORD_W register with beat-granular write and read.
//   clk, reset  : clock, asynchronous active-low reset
//   wr_en       : write one beat this cycle
//   wr_msb      : 1 = shift beat in at the bottom (MSB-first stream),
//                 0 = write beat into slice wr_idx (LSB-first stream)
//   wr_idx      : beat slot for LSB-first writes
//   wr_data     : beat to write
//   ld_en       : load the whole word from ld_data (takes priority)
//   rd_idx      : beat slot presented on rd_data
//   rd_data     : selected beat
//   q           : full register contents
module io_serdes_word
  import io_serdes_pkg::*;
#(
  parameter int unsigned BUS_W  = DEF_BUS_W,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned IW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_msb,
  input  logic [IW-1:0]     wr_idx,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic              ld_en,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [BUS_W-1:0]  rd_data,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_en) begin
      q_d = ld_data;
    end else if (wr_en) begin
      if (wr_msb) q_d = {q_q[WORD_W-BUS_W-1:0], wr_data};
      else        q_d[BUS_W*wr_idx +: BUS_W] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign rd_data = q_q[BUS_W*rd_idx +: BUS_W];
  assign q       = q_q;

endmodule

// File: rtl/io_serdes_gen.sv
// io_serdes_gen: deserialises N_OPS operands from a BUS_W bus, pulses
// start_calc, captures the core result on calc_done and streams it back
// under ready/valid. Beat order is latched per transaction from msb_first.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid, inputs    : inbound beat stream
//   msb_first           : beat order, sampled on the first beat of a transaction
//   operands            : operand i at [WORD_W*i +: WORD_W]
//   start_calc          : one-cycle pulse once all operands are loaded
//   calc_done, z        : result handshake from the core
//   outputs, out_valid  : registered outbound beat
//   out_ready           : sink accepts the beat
//   overrun             : one-cycle pulse when a beat arrives outside LOAD
// Build option: IO_SERDES_CHECKSUM_EN appends an XOR-of-beats checksum beat.
//
// state   | meaning
// ST_LOAD | accepting operand beats
// ST_CALC | start_calc issued, waiting for calc_done
// ST_OUT  | streaming result beats (plus checksum when enabled)
module io_serdes_gen
  import io_serdes_pkg::*;
#(
  parameter int unsigned BUS_W  = DEF_BUS_W,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned N_OPS  = DEF_N_OPS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BUS_W-1:0]        inputs,
  input  logic                    msb_first,
  output logic [N_OPS*WORD_W-1:0] operands,
  output logic                    start_calc,
  input  logic                    calc_done,
  input  logic [WORD_W-1:0]       z,
  output logic [BUS_W-1:0]        outputs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned BEATS = beats_of(WORD_W, BUS_W);
`ifdef IO_SERDES_CHECKSUM_EN
  localparam int unsigned N_OUT = BEATS + 1;
`else
  localparam int unsigned N_OUT = BEATS;
`endif
  localparam int unsigned CW = cnt_w(N_OUT);
  localparam int unsigned OW = cnt_w(N_OPS);
  localparam logic [CW-1:0] LAST_IN  = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(N_OUT - 1);
  localparam logic [OW-1:0] LAST_OP  = OW'(N_OPS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]     op_cnt_q, op_cnt_d;
  logic              mode_q, mode_d;
  logic              start_calc_q, start_calc_d;
  logic              overrun_q, overrun_d;
  logic              out_valid_q, out_valid_d;
  logic [BUS_W-1:0]  outputs_q, outputs_d;

  logic [N_OPS-1:0]       op_wr_en;
  logic                   wr_msb;
  logic                   res_ld;
  logic [CW-1:0]          out_idx_nxt;
  logic [CW-1:0]          res_rd_idx;
  logic [BUS_W-1:0]       res_rd;
  logic [WORD_W-1:0]      res_q;
  logic [N_OPS*BUS_W-1:0] op_rd_unused;

  for (genvar i = 0; i < N_OPS; i++) begin : g_op
    io_serdes_word #(.BUS_W(BUS_W), .WORD_W(WORD_W), .IW(CW)) u_op (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (op_wr_en[i]),
      .wr_msb  (wr_msb),
      .wr_idx  (beat_cnt_q),
      .wr_data (inputs),
      .ld_en   (1'b0),
      .ld_data ('0),
      .rd_idx  ('0),
      .rd_data (op_rd_unused[BUS_W*i +: BUS_W]),
      .q       (operands[WORD_W*i +: WORD_W])
    );
  end

  io_serdes_word #(.BUS_W(BUS_W), .WORD_W(WORD_W), .IW(CW)) u_res (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (1'b0),
    .wr_msb  (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (res_ld),
    .ld_data (z),
    .rd_idx  (res_rd_idx),
    .rd_data (res_rd),
    .q       (res_q)
  );

`ifdef IO_SERDES_CHECKSUM_EN
  logic [BUS_W-1:0] csum;
  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < BEATS; i++) csum = csum ^ res_q[BUS_W*i +: BUS_W];
  end
`else
  logic unused_res;
  assign unused_res = ^res_q;
`endif

  // Beat index is kept in stream order; the physical slot is mirrored for MSB-first.
  assign out_idx_nxt = beat_cnt_q + CW'(1);
  assign res_rd_idx  = mode_q ? (LAST_IN - out_idx_nxt) : out_idx_nxt;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    op_cnt_d     = op_cnt_q;
    mode_d       = mode_q;
    start_calc_d = 1'b0;
    overrun_d    = 1'b0;
    out_valid_d  = out_valid_q;
    outputs_d    = outputs_q;
    op_wr_en     = '0;
    wr_msb       = mode_q;
    res_ld       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          // The first beat must already use the order it latches.
          if (op_cnt_q == '0 && beat_cnt_q == '0) begin
            mode_d = msb_first;
            wr_msb = msb_first;
          end
          for (int unsigned i = 0; i < N_OPS; i++) op_wr_en[i] = (op_cnt_q == OW'(i));
          if (beat_cnt_q == LAST_IN) begin
            beat_cnt_d = '0;
            if (op_cnt_q == LAST_OP) begin
              op_cnt_d     = '0;
              state_d      = ST_CALC;
              start_calc_d = 1'b1;
            end else begin
              op_cnt_d = op_cnt_q + OW'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_CALC: begin
        overrun_d = in_valid;
        if (calc_done) begin
          res_ld      = 1'b1;
          outputs_d   = mode_q ? z[WORD_W-1 -: BUS_W] : z[BUS_W-1:0];
          out_valid_d = 1'b1;
          beat_cnt_d  = '0;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        overrun_d = in_valid;
        if (out_valid_q && out_ready) begin
          if (beat_cnt_q == LAST_OUT) begin
            out_valid_d = 1'b0;
            outputs_d   = '0;
            beat_cnt_d  = '0;
            op_cnt_d    = '0;
            state_d     = ST_LOAD;
          end else begin
            beat_cnt_d = out_idx_nxt;
            outputs_d  = res_rd;
`ifdef IO_SERDES_CHECKSUM_EN
            if (out_idx_nxt == CW'(BEATS)) outputs_d = csum;
`endif
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      beat_cnt_q   <= '0;
      op_cnt_q     <= '0;
      mode_q       <= 1'b0;
      start_calc_q <= 1'b0;
      overrun_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      outputs_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      op_cnt_q     <= op_cnt_d;
      mode_q       <= mode_d;
      start_calc_q <= start_calc_d;
      overrun_q    <= overrun_d;
      out_valid_q  <= out_valid_d;
      outputs_q    <= outputs_d;
    end
  end

  assign start_calc = start_calc_q;
  assign overrun    = overrun_q;
  assign out_valid  = out_valid_q;
  assign outputs    = outputs_q;

endmodule
